io_output_port: RTL



---
 rtl/io_output_port_pkg.sv | 47 ++++
 rtl/io_output_port_if.sv | 10 +
 rtl/io_output_port_seg7.sv | 32 +++
 rtl/io_output_port.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/io_output_port_pkg.sv
// Shared constants, state encoding and helpers for the memory-mapped
// decimal/LED output port.
package io_output_pkg;

    localparam logic [31:0] ADDR_DEC  = 32'h0000_0080;
    localparam logic [31:0] ADDR_LED  = 32'h0000_0084;
    localparam logic [31:0] ADDR_STAT = 32'h0000_0088;

    localparam logic [31:0] DEC_MAX    = 32'd999999;
    localparam int unsigned CONV_BITS  = 20;
    localparam logic [4:0]  LAST_SHIFT = 5'(CONV_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Shift-add-3 correction: every BCD nibble >= 5 gets 3 added before the shift
    function automatic logic [23:0] bcd_adjust(input logic [23:0] bcd);
        logic [23:0] res;
        res = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/io_output_port_if.sv
// CPU data-bus slice seen by the output port.
interface io_output_port_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output wmem, input rdata);
    modport slave  (input addr, input wdata, input wmem, output rdata);
endinterface

// File: rtl/io_output_port_seg7.sv
// One BCD digit to active-low seven-segment pattern, with blanking.
module seg7_decode
    import io_output_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Digit lookup; blank flag and non-decimal codes turn the digit off
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/io_output_port.sv
// Memory-mapped output port: decimal display via iterative binary-to-BCD
// conversion, a directly written LED register and a busy status register.
module io_output_port
    import io_output_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    io_output_port_if.slave   bus,
    output logic              busy,
    output logic [6:0]        hex5,
    output logic [6:0]        hex4,
    output logic [6:0]        hex3,
    output logic [6:0]        hex2,
    output logic [6:0]        hex1,
    output logic [6:0]        hex0,
    output logic [9:0]        led
);

    state_t      state_r, state_nx_s;
    logic [31:0] dec_r;
    logic [19:0] bin_r;
    logic [23:0] bcd_r;
    logic [23:0] bcd_adj_s;
    logic        ovf_r;
    logic [4:0]  cnt_r;
    logic        busy_r;
    logic [9:0]  led_r;
    logic [6:0]  hex_r      [6];
    logic [6:0]  dig_seg_s  [6];
    logic [6:0]  disp_seg_s [6];
    logic [5:0]  blank_s;
    logic        trig_s, led_wr_s;
    logic        load_s, shift_s, latch_s;

    assign trig_s    = bus.wmem && (bus.addr == ADDR_DEC);
    assign led_wr_s  = bus.wmem && (bus.addr == ADDR_LED);
    assign bcd_adj_s = bcd_adjust(bcd_r);

    // Leading-zero blanking: a digit is dark when it and every digit above are zero
    assign blank_s[0] = 1'b0;
    for (genvar g = 1; g < 6; g++) begin : g_blank
        assign blank_s[g] = (bcd_r[23:4*g] == '0);
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        seg7_decode u_seg (
            .bcd   (bcd_r[4*g +: 4]),
            .blank (blank_s[g]),
            .seg   (dig_seg_s[g])
        );
    end

    // Overflowed values show dashes on every digit
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            if (ovf_r) begin
                disp_seg_s[i] = SEG_DASH;
            end else begin
                disp_seg_s[i] = dig_seg_s[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and datapath strobes; a new store always restarts
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        latch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (trig_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else if (cnt_r == LAST_SHIFT) begin
                    shift_s    = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    shift_s    = 1'b1;
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                latch_s = 1'b1;
                if (trig_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Conversion datapath, display latch, LED register and busy flag
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dec_r  <= 32'd0;
            bin_r  <= 20'd0;
            bcd_r  <= 24'd0;
            ovf_r  <= 1'b0;
            cnt_r  <= 5'd0;
            busy_r <= 1'b0;
            led_r  <= 10'd0;
            hex_r[0] <= SEG_0;
            for (int i = 1; i < 6; i++) begin
                hex_r[i] <= SEG_BLANK;
            end
        end else begin
            if (led_wr_s) begin
                led_r <= bus.wdata[9:0];
            end
            if (load_s) begin
                dec_r <= bus.wdata;
                bin_r <= bus.wdata[19:0];
                bcd_r <= 24'd0;
                ovf_r <= (bus.wdata > DEC_MAX);
                cnt_r <= 5'd0;
            end else if (shift_s) begin
                {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1'b1;
                cnt_r <= cnt_r + 5'd1;
            end
            if (latch_s) begin
                hex_r <= disp_seg_s;
            end
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    // Status/readback mux, combinational from the address
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_DEC:  bus.rdata = dec_r;
            ADDR_LED:  bus.rdata = {22'd0, led_r};
            ADDR_STAT: bus.rdata = {31'd0, busy_r};
            default:   bus.rdata = 32'd0;
        endcase
    end

    assign busy = busy_r;
    assign led  = led_r;
    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];
    assign hex4 = hex_r[4];
    assign hex5 = hex_r[5];

endmodule
